// File: rtl/downsample_mov_sum_pkg.sv
// downsample_mov_sum_pkg: shared defaults and state type for the downsampling moving-sum block
package downsample_mov_sum_pkg;

    localparam int DEF_DATA_W    = 10;
    localparam int DEF_DS_W      = 14;
    localparam int DEF_SUM_W     = 32;
    localparam int DEF_WIN_DEPTH = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/downsample_mov_sum_win_ram.sv
// win_ram: DEPTH x WIDTH simple dual-port history buffer
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port
//   raddr : read address, rdata : asynchronous read (returns pre-write contents on an address collision)
module win_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 14,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/downsample_mov_sum.sv
// downsample_mov_sum: sums every N FIFO samples, then keeps a moving sum over the last W downsampled values
//   ap_clk, ap_rst_n                 : clock, async active-low reset
//   ap_start/ap_ready/ap_idle/ap_done: start handshake, ap_done mirrors sumout_vld
//   absolute_value, downsample_num,
//   window_width                     : configuration, latched on an accepted start
//   datain_dout/empty_n/read         : first-word-fall-through FIFO input
//   ds_sum/ds_vld                    : downsampled sum and its strobe
//   sumout/sumout_vld                : moving sum and its strobe
module downsample_mov_sum
    import downsample_mov_sum_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DS_W      = DEF_DS_W,
    parameter int SUM_W     = DEF_SUM_W,
    parameter int WIN_DEPTH = DEF_WIN_DEPTH
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    output logic                     ap_ready,
    output logic                     ap_idle,
    output logic                     ap_done,
    input  logic                     absolute_value,
    input  logic [7:0]               downsample_num,
    input  logic [7:0]               window_width,
    input  logic signed [DATA_W-1:0] datain_dout,
    input  logic                     datain_empty_n,
    output logic                     datain_read,
    output logic signed [DS_W-1:0]   ds_sum,
    output logic                     ds_vld,
    output logic signed [SUM_W-1:0]  sumout,
    output logic                     sumout_vld
);

    localparam int PW = $clog2(WIN_DEPTH);

    state_t state, state_nxt;
    logic abs_q;
    logic [7:0] n_q, w_q, cnt, fill;
    logic signed [DS_W-1:0] acc, smp_ext, smp_val, acc_nxt, old_raw, old_val;
    logic last;
    logic [PW-1:0] wptr, rptr;

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb state_nxt = (state == IDLE && ap_start) ? RUN : state;

    // ap_ready is combinational from ap_start, so it is gated by reset to stay low while held in reset
    always_comb begin
        ap_idle     = state == IDLE;
        ap_ready    = ap_rst_n && state == IDLE && ap_start;
        datain_read = state == RUN && datain_empty_n;
    end

    assign ap_done = sumout_vld;

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            abs_q <= 1'b0;
            n_q   <= 8'd1;
            w_q   <= 8'd1;
        end else if (ap_ready) begin
            abs_q <= absolute_value;
            n_q   <= downsample_num == 8'd0 ? 8'd1 : downsample_num;
            w_q   <= window_width == 8'd0 ? 8'd1 : window_width;
        end

    // Extend before negating so the most negative sample has a representable magnitude
    assign smp_ext = DS_W'(datain_dout);
    assign smp_val = (abs_q && smp_ext < 0) ? -smp_ext : smp_ext;
    assign acc_nxt = acc + smp_val;
    assign last    = cnt == n_q - 8'd1;

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            ds_sum <= '0;
            ds_vld <= 1'b0;
        end else begin
            ds_vld <= datain_read && last;
            if (datain_read) begin
                acc <= last ? '0 : acc_nxt;
                cnt <= last ? 8'd0 : cnt + 8'd1;
                if (last) ds_sum <= acc_nxt;
            end
        end

    // Oldest entry of the window sits W slots behind the write pointer; fill saturates at W
    assign rptr    = PW'((32'(wptr) + 32'(WIN_DEPTH) - 32'(w_q)) % 32'(WIN_DEPTH));
    assign old_val = fill == w_q ? old_raw : '0;

    win_ram #(
        .DEPTH(WIN_DEPTH),
        .WIDTH(DS_W)
    ) u_win_ram (
        .clk  (ap_clk),
        .we   (ds_vld),
        .waddr(wptr),
        .wdata(ds_sum),
        .raddr(rptr),
        .rdata(old_raw)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            wptr       <= '0;
            fill       <= '0;
            sumout     <= '0;
            sumout_vld <= 1'b0;
        end else begin
            sumout_vld <= ds_vld;
            if (ds_vld) begin
                sumout <= sumout + SUM_W'(ds_sum) - SUM_W'(old_val);
                wptr   <= (32'(wptr) == WIN_DEPTH - 1) ? '0 : wptr + PW'(1);
                fill   <= fill == w_q ? fill : fill + 8'd1;
            end
        end

endmodule

// File: tb/tb_downsample_mov_sum.sv
// tb_downsample_mov_sum: directed and randomized checks of downsample_mov_sum against a window-sum model
module tb_downsample_mov_sum;

    localparam int DATA_W    = 10;
    localparam int DS_W      = 14;
    localparam int SUM_W     = 32;
    localparam int WIN_DEPTH = 256;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b1;
    logic ap_start = 1'b0;
    logic absolute_value = 1'b0;
    logic [7:0] downsample_num = 8'd0;
    logic [7:0] window_width = 8'd0;
    logic signed [DATA_W-1:0] datain_dout = '0;
    logic datain_empty_n = 1'b0;
    logic ap_ready, ap_idle, ap_done, datain_read, ds_vld, sumout_vld;
    logic signed [DS_W-1:0] ds_sum;
    logic signed [SUM_W-1:0] sumout;

    downsample_mov_sum #(
        .DATA_W(DATA_W),
        .DS_W(DS_W),
        .SUM_W(SUM_W),
        .WIN_DEPTH(WIN_DEPTH)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_idle(ap_idle),
        .ap_done(ap_done),
        .absolute_value(absolute_value),
        .downsample_num(downsample_num),
        .window_width(window_width),
        .datain_dout(datain_dout),
        .datain_empty_n(datain_empty_n),
        .datain_read(datain_read),
        .ds_sum(ds_sum),
        .ds_vld(ds_vld),
        .sumout(sumout),
        .sumout_vld(sumout_vld)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int mon_ds[$], mon_ds_c[$], mon_sum[$], mon_sum_c[$], read_c[$];
    int done_bad = 0;

    always @(negedge ap_clk) begin
        if (ds_vld) begin
            mon_ds.push_back(int'(ds_sum));
            mon_ds_c.push_back(cyc);
        end
        if (sumout_vld) begin
            mon_sum.push_back(int'(sumout));
            mon_sum_c.push_back(cyc);
        end
        if (ap_done !== sumout_vld) done_bad++;
    end

    function automatic void model(input int s[$], input bit ab, input int n, input int w,
                                  output int eds[$], output int esum[$]);
        int ne, we, t, v, acc;
        logic signed [DS_W-1:0] tw;
        ne = n == 0 ? 1 : n;
        we = w == 0 ? 1 : w;
        eds = {};
        esum = {};
        for (int g = 0; (g + 1) * ne <= s.size(); g++) begin
            t = 0;
            for (int k = 0; k < ne; k++) begin
                v = s[g * ne + k];
                if (ab && v < 0) v = -v;
                t += v;
            end
            tw = DS_W'(t);
            eds.push_back(int'(tw));
        end
        for (int i = 0; i < eds.size(); i++) begin
            acc = 0;
            for (int j = (i - we + 1 < 0 ? 0 : i - we + 1); j <= i; j++) acc += eds[j];
            esum.push_back(acc);
        end
    endfunction

    function automatic void gen(input int len, output int q[$]);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 1023)) - 512);
    endfunction

    task automatic start_run(input bit ab, input int n, input int w);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        datain_empty_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        absolute_value = ab;
        downsample_num = 8'(n);
        window_width = 8'(w);
        ap_start = 1'b1;
        #1;
        n_vec++;
        if (ap_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_ready got %b want 1", ap_ready);
        end
        @(posedge ap_clk);
        mon_ds = {};
        mon_ds_c = {};
        mon_sum = {};
        mon_sum_c = {};
        read_c = {};
        done_bad = 0;
        @(negedge ap_clk);
        #1;
        n_vec++;
        if (ap_ready !== 1'b0 || ap_idle !== 1'b0) begin
            n_err++;
            $display("FAIL run_start_ignored ready/idle got %b/%b want 0/0", ap_ready, ap_idle);
        end
        ap_start = 1'b0;
        absolute_value = ~ab;
        downsample_num = 8'(n + 3);
        window_width = 8'(w + 5);
    endtask

    task automatic feed(input int s[$], input int mode);
        int idx, budget;
        bit en, ph;
        idx = 0;
        budget = 20 * s.size() + 100;
        ph = 1'b0;
        while (idx < s.size() && budget > 0) begin
            @(negedge ap_clk);
            budget--;
            en = mode == 0 ? 1'b1 : mode == 1 ? ph : 1'($urandom_range(0, 1));
            ph = ~ph;
            datain_empty_n = en;
            datain_dout = en ? DATA_W'(s[idx]) : DATA_W'($urandom);
            #1;
            n_vec++;
            if (datain_read !== en) begin
                n_err++;
                $display("FAIL datain_read got %b want %b", datain_read, en);
            end
            if (en) begin
                read_c.push_back(cyc);
                idx++;
            end
        end
        n_vec++;
        if (idx < s.size()) begin
            n_err++;
            $display("FAIL feed_timeout consumed %0d want %0d", idx, s.size());
        end
        @(negedge ap_clk);
        datain_empty_n = 1'b0;
        repeat (4) @(negedge ap_clk);
    endtask

    task automatic check(input string name, input int n, input int eds[$], input int esum[$]);
        int ne, ri;
        ne = n == 0 ? 1 : n;
        n_vec++;
        if (mon_ds.size() != eds.size() || mon_sum.size() != esum.size()) begin
            n_err++;
            $display("FAIL %s count ds/sum got %0d/%0d want %0d/%0d", name,
                     mon_ds.size(), mon_sum.size(), eds.size(), esum.size());
            return;
        end
        for (int i = 0; i < eds.size(); i++) begin
            n_vec++;
            if (mon_ds[i] !== eds[i] || mon_sum[i] !== esum[i]) begin
                n_err++;
                $display("FAIL %s value[%0d] ds/sum got %0d/%0d want %0d/%0d", name, i,
                         mon_ds[i], mon_sum[i], eds[i], esum[i]);
            end
            ri = i * ne + ne - 1;
            n_vec++;
            if (ri >= read_c.size() || mon_ds_c[i] !== read_c[ri] + 1 || mon_sum_c[i] !== read_c[ri] + 2) begin
                n_err++;
                $display("FAIL %s latency[%0d] ds/sum cycle got %0d/%0d want %0d/%0d", name, i,
                         mon_ds_c[i], mon_sum_c[i],
                         ri < read_c.size() ? read_c[ri] + 1 : -1, ri < read_c.size() ? read_c[ri] + 2 : -1);
            end
        end
        if (eds.size() > 0) begin
            n_vec++;
            if (int'(ds_sum) !== eds[eds.size()-1] || int'(sumout) !== esum[esum.size()-1]) begin
                n_err++;
                $display("FAIL %s hold ds/sum got %0d/%0d want %0d/%0d", name, ds_sum, sumout,
                         eds[eds.size()-1], esum[esum.size()-1]);
            end
        end
        n_vec++;
        if (done_bad !== 0) begin
            n_err++;
            $display("FAIL %s ap_done_vs_sumout_vld mismatching cycles got %0d want 0", name, done_bad);
        end
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        ap_start = 1'b1;
        datain_empty_n = 1'b1;
        ap_rst_n = 1'b0;
        #1;
        n_vec++;
        if (ap_idle !== 1'b1 || ap_ready !== 1'b0 || ap_done !== 1'b0 || ds_vld !== 1'b0 ||
            sumout_vld !== 1'b0 || datain_read !== 1'b0 || ds_sum !== '0 || sumout !== '0) begin
            n_err++;
            $display("FAIL reset_outputs idle/ready/done/dsv/sv/rd/ds/sum got %b%b%b%b%b%b/%0d/%0d want 100000/0/0",
                     ap_idle, ap_ready, ap_done, ds_vld, sumout_vld, datain_read, ds_sum, sumout);
        end
        @(negedge ap_clk);
        ap_start = 1'b0;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        #1;
        n_vec++;
        if (ap_idle !== 1'b1 || datain_read !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset idle/read got %b/%b want 1/0", ap_idle, datain_read);
        end
        datain_empty_n = 1'b0;
    endtask

    task automatic test_n1_w3();
        int s[$], e_ds[$], e_sum[$];
        s = {1, 2, 3, 4};
        e_ds = {1, 2, 3, 4};
        e_sum = {1, 3, 6, 9};
        start_run(1'b0, 1, 3);
        feed(s, 0);
        check("n1_w3", 1, e_ds, e_sum);
    endtask

    task automatic test_n2_w3();
        int s[$], e_ds[$], e_sum[$];
        s = {1, 2, 3, 4, 5, 6, 7, 8};
        e_ds = {3, 7, 11, 15};
        e_sum = {3, 10, 21, 33};
        start_run(1'b0, 2, 3);
        feed(s, 0);
        check("n2_w3", 2, e_ds, e_sum);
    endtask

    task automatic test_abs();
        int s[$], e_ds[$], e_sum[$];
        s = {(-5), (-3)};
        e_ds = {8};
        e_sum = {8};
        start_run(1'b1, 2, 1);
        feed(s, 0);
        check("abs_on", 2, e_ds, e_sum);
        e_ds = {(-8)};
        e_sum = {(-8)};
        start_run(1'b0, 2, 1);
        feed(s, 0);
        check("abs_off", 2, e_ds, e_sum);
    endtask

    task automatic test_gaps();
        int s[$], e_ds[$], e_sum[$];
        s = {1, 1, 1, 1};
        e_ds = {2, 2};
        e_sum = {2, 4};
        start_run(1'b0, 2, 3);
        feed(s, 1);
        check("toggle_empty", 2, e_ds, e_sum);
    endtask

    task automatic test_reset_mid();
        int s[$], e_ds[$], e_sum[$];
        s = {9, 9, 9};
        start_run(1'b0, 2, 2);
        feed(s, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        n_vec++;
        if (ds_sum !== '0 || sumout !== '0 || ap_idle !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_clear ds/sum/idle got %0d/%0d/%b want 0/0/1", ds_sum, sumout, ap_idle);
        end
        s = {4, 4};
        e_ds = {8};
        e_sum = {8};
        start_run(1'b0, 2, 2);
        feed(s, 0);
        check("restart_no_stale", 2, e_ds, e_sum);
    endtask

    task automatic test_cfg_change();
        int s[$], e_ds[$], e_sum[$];
        s = {(-1), 2, 3};
        e_ds = {(-1), 2, 3};
        e_sum = {(-1), 2, 3};
        start_run(1'b0, 1, 1);
        feed(s, 0);
        check("cfg_change_ignored", 1, e_ds, e_sum);
    endtask

    task automatic test_random();
        int s[$], e_ds[$], e_sum[$];
        bit ab;
        int n, w;
        for (int it = 0; it < 9; it++) begin
            ab = 1'($urandom_range(0, 1));
            n = it == 0 ? 0 : int'($urandom_range(0, 5));
            w = it == 0 ? 0 : it == 8 ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 9));
            gen(it == 8 ? 600 : 36, s);
            if (it == 8) n = 1;
            model(s, ab, n, w, e_ds, e_sum);
            start_run(ab, n, w);
            feed(s, int'($urandom_range(0, 2)));
            check($sformatf("random%0d", it), n, e_ds, e_sum);
        end
    endtask

    initial begin
        test_reset();
        test_n1_w3();
        test_n2_w3();
        test_abs();
        test_gaps();
        test_reset_mid();
        test_cfg_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
